video_fade_ctl: RTL and testbench

Frame-synchronous fade sequencer that produces the 8-bit `rate` consumed by the video alpha mixer. Software or a sequencer issues a fade command (target rate, step size, frames per step). The block then ramps `rate` toward the target, updating only on frame-start ticks so every displayed frame uses one constant blend ratio. It sits in the video clock domain between the register interface and the mixer's `rate` input.

---
 rtl/video_fade_ctl.sv | 97 +++++++++
 tb/tb_video_fade_ctl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/video_fade_ctl.sv
// Frame-synchronous fade sequencer: ramps the mixer blend rate toward a
// commanded target, changing it only on frame-start ticks.
module video_fade_ctl #(
    parameter logic [7:0] RESET_RATE = 8'hff
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_target,
    input  logic [7:0] cmd_step,
    input  logic [7:0] cmd_frames,
    input  logic       abort,
    output logic [7:0] rate,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [7:0] tgt, stp, frm, frame_cnt;
    logic [7:0] frames_eff;
    logic [7:0] next_rate;
    logic [8:0] up_sum, dn_lim;

    assign frames_eff = (cmd_frames == 8'd0) ? 8'd1 : cmd_frames;

    // 9-bit compares so rate+step and target+step never wrap
    always_comb begin
        up_sum    = {1'b0, rate} + {1'b0, stp};
        dn_lim    = {1'b0, tgt} + {1'b0, stp};
        next_rate = tgt;
        if (stp != 8'd0) begin
            if (rate < tgt)
                next_rate = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[7:0];
            else
                next_rate = ({1'b0, rate} >= dn_lim) ? (rate - stp) : tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rate      <= RESET_RATE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
            tgt       <= 8'd0;
            stp       <= 8'd0;
            frm       <= 8'd0;
            frame_cnt <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tgt       <= cmd_target;
                        stp       <= cmd_step;
                        frm       <= frames_eff;
                        frame_cnt <= frames_eff;
                        if (cmd_target == rate) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (frame_tick) begin
                        if (frame_cnt > 8'd1) begin
                            frame_cnt <= frame_cnt - 8'd1;
                        end else begin
                            rate      <= next_rate;
                            frame_cnt <= frm;
                            if (next_rate == tgt) begin
                                done      <= 1'b1;
                                state     <= IDLE;
                                busy      <= 1'b0;
                                cmd_ready <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_fade_ctl.sv
// Directed and random checks of video_fade_ctl against a tick-counting
// arithmetic model of the fade.
module tb_video_fade_ctl;

    logic       clk = 1'b0;
    logic       rst, frame_tick, cmd_valid, abort;
    logic [7:0] cmd_target, cmd_step, cmd_frames;
    logic       cmd_ready, busy, done;
    logic [7:0] rate;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;

    // model state
    int m_rate = 255, m_tgt = 0, m_step = 0, m_frames = 1, m_ticks = 0;
    bit m_busy = 0, m_done = 0;

    video_fade_ctl #(.RESET_RATE(8'hff)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_frames(cmd_frames),
        .abort(abort), .rate(rate), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a fade is a count of ticks since accept; every frames-th tick
    // moves the rate by step toward the target, clamped.
    task automatic model_step();
        m_done = 0;
        if (rst) begin
            m_rate = 255; m_busy = 0; m_ticks = 0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_tgt    = cmd_target;
                m_step   = cmd_step;
                m_frames = (cmd_frames == 0) ? 1 : int'(cmd_frames);
                m_ticks  = 0;
                if (m_tgt == m_rate) m_done = 1;
                else m_busy = 1;
            end
        end else if (abort) begin
            m_busy = 0;
        end else if (frame_tick) begin
            m_ticks++;
            if (m_ticks % m_frames == 0) begin
                if (m_step == 0)           m_rate = m_tgt;
                else if (m_rate < m_tgt)   m_rate = (m_rate + m_step > m_tgt) ? m_tgt : m_rate + m_step;
                else                       m_rate = (m_rate - m_step < m_tgt) ? m_tgt : m_rate - m_step;
                if (m_rate == m_tgt) begin
                    m_done = 1; m_busy = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit v, input bit t, input bit a, input bit r,
                       input logic [7:0] tg = 8'h00, input logic [7:0] st = 8'h00,
                       input logic [7:0] fr = 8'h00);
        cmd_valid = v; frame_tick = t; abort = a; rst = r;
        cmd_target = tg; cmd_step = st; cmd_frames = fr;
        model_step();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        chk("rate", rate, 8'(m_rate));
        chk("busy", {7'd0, busy}, {7'd0, m_busy});
        chk("done", {7'd0, done}, {7'd0, m_done});
        chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, !m_busy});
        cmd_valid = 0; frame_tick = 0; abort = 0; rst = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] fall_seq [4];
        fall_seq[0] = 8'hbf; fall_seq[1] = 8'h7f; fall_seq[2] = 8'h3f; fall_seq[3] = 8'h00;

        // reset
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("reset_rate", rate, 8'hff);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_ready", {7'd0, cmd_ready}, 8'd1);
        chk("reset_done", {7'd0, done}, 8'd0);
        idle(2);

        // falling fade, step 0x40, 2 frames per step
        done_cnt = 0;
        cyc(1, 0, 0, 0, 8'h00, 8'h40, 8'h02);
        chk("fall_busy", {7'd0, busy}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0);
            if (i % 2 == 1) chk("fall_rate", rate, fall_seq[i/2]);
            idle(2);
        end
        chk("fall_done_cnt", 8'(done_cnt), 8'd1);
        chk("fall_idle", {7'd0, busy}, 8'd0);

        // get to 0x10 via a step-0 jump, then rising clamp
        cyc(1, 0, 0, 0, 8'h10, 8'h00, 8'h01);
        cyc(0, 1, 0, 0);
        chk("jump_rate", rate, 8'h10);
        idle(1);
        cyc(1, 0, 0, 0, 8'hf0, 8'hff, 8'h00);
        idle(1);
        cyc(0, 1, 0, 0);
        chk("rise_rate", rate, 8'hf0);
        chk("rise_done", {7'd0, done}, 8'd1);
        idle(1);

        // no-op command
        cyc(1, 0, 0, 0, 8'hf0, 8'h05, 8'h01);
        chk("noop_done", {7'd0, done}, 8'd1);
        chk("noop_busy", {7'd0, busy}, 8'd0);
        idle(2);

        // ignored command during RUN
        cyc(1, 0, 0, 0, 8'h00, 8'h10, 8'h01);
        cyc(1, 0, 0, 0, 8'h80, 8'h01, 8'h01);
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0);
        chk("ignored_rate", rate, 8'h00);
        idle(2);

        // abort together with a qualifying tick
        cyc(1, 0, 0, 0, 8'hff, 8'h10, 8'h01);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        done_cnt = 0;
        cyc(0, 1, 1, 0);
        chk("abort_rate", rate, 8'h20);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
        cyc(0, 1, 0, 0);
        chk("abort_frozen", rate, 8'h20);
        chk("abort_no_done", 8'(done_cnt), 8'd0);

        // reset mid-fade
        cyc(1, 0, 0, 0, 8'h00, 8'h01, 8'h01);
        cyc(0, 1, 0, 0);
        chk("pre_rst_rate", rate, 8'h1f);
        cyc(0, 0, 0, 1);
        chk("rst_rate", rate, 8'hff);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        chk("rst_hold", rate, 8'hff);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 48)),
                8'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
